riscv_multicycle_control: RTL and testbench
===========================================

RISCV_MULTICYCLE_CONTROL -- requirements
Module: riscv_multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, memory read latency in cycles (legal range 1..7).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i31_0  input  32  current IR contents; opcode [6:0], funct3 [14:12], funct7 [31:25].
REQ-005 SHALL have port AluIgual  input  1  ALU equality flag, valid in the BRANCH cycle.
REQ-006 SHALL have port PCwrite  output  1  PC load enable.
REQ-007 SHALL have port LoadIR  output  1  instruction register load enable.
REQ-008 SHALL have port RegWrite  output  1  register-file write enable.
REQ-009 SHALL have port loadRegA  output  1  register A load enable.
REQ-010 SHALL have port loadRegB  output  1  register B load enable.
REQ-011 SHALL have port loadRegAluOut  output  1  AluOut register load enable.
REQ-012 SHALL have port loadRegMemData  output  1  memory-data register load enable.
REQ-013 SHALL have port MemRead  output  1  instruction-memory access; 0 = read (the only value this block drives).
REQ-014 SHALL have port MemData_Read  output  1  data-memory access; 0 = read, 1 = write.
REQ-015 SHALL have port SelMuxA  output  3  ALU A select: 0 = PC, 1 = RegA.
REQ-016 SHALL have port SelMuxB  output  3  ALU B select: 0 = RegB, 1 = constant 4, 2 = SignExit, 3 = ShiftLeftExit.
REQ-017 SHALL have port SelMuxMem  output  3  write-back select: 0 = AluOut, 1 = MemDataReg, 2 = SignExit (U-immediate).
REQ-018 SHALL have port SelMuxPC  output  1  PC source: 0 = AluExit, 1 = AluOut.
REQ-019 SHALL have port AluOperation  output  3  ALU op: 000 pass A, 001 add, 010 sub, 011 and.
REQ-020 SHALL have port State  output  4  current state encoding, for debug.

Function
REQ-021 SHALL implement states FETCH, FETCH_WAIT, DECODE, R_EXEC, I_EXEC, ALU_WB, ADDR, LD_MEM, LD_WAIT, LD_WB, SD_MEM, BRANCH, BR_NT, LUI_WB, HALT.
REQ-022 SHALL drive every output to 0 in any cycle in which that output is not explicitly asserted.
REQ-023 FETCH SHALL last 1 cycle with MemRead=0, then transition to FETCH_WAIT.
REQ-024 FETCH_WAIT SHALL last exactly MEM_WAIT cycles, counted by a wait counter, and SHALL assert LoadIR in its final cycle only.
REQ-025 DECODE SHALL assert loadRegA, loadRegB and loadRegAluOut with SelMuxA=0, SelMuxB=3 and add, precomputing the branch target.
REQ-026 DECODE SHALL dispatch on opcode as follows: 0110011 -> R_EXEC; 0010011 -> I_EXEC; 0000011 with funct3=011 -> ADDR; 0100011 with funct3=111 -> ADDR; 1100011 with funct3 000/001 -> BRANCH; 0110111 -> LUI_WB; any other opcode -> HALT.
REQ-027 R_EXEC SHALL drive SelMuxA=1, SelMuxB=0 and loadRegAluOut, with op selected by funct3 and funct7: add (000/0000000), sub (000/0100000), and (111/0000000); any other combination -> HALT with no load.
REQ-028 I_EXEC and ADDR SHALL drive SelMuxA=1, SelMuxB=2, add and loadRegAluOut.
REQ-029 ADDR SHALL go to LD_MEM for a load and to SD_MEM for a store.
REQ-030 LD_MEM SHALL last 1 cycle, followed by LD_WAIT lasting MEM_WAIT cycles, with loadRegMemData asserted in the last LD_WAIT cycle.
REQ-031 Every final cycle (ALU_WB, LD_WB, SD_MEM, LUI_WB, BR_NT) SHALL assert PCwrite with SelMuxA=0, SelMuxB=1, add and SelMuxPC=0 (PC+4), then return to FETCH.
REQ-032 ALU_WB, LD_WB and LUI_WB SHALL assert RegWrite with SelMuxMem 0, 1 and 2 respectively.
REQ-033 SD_MEM SHALL assert MemData_Read=1 for exactly one cycle.
REQ-034 BRANCH SHALL drive SelMuxA=1, SelMuxB=0 and sub.
REQ-035 In BRANCH, the branch is taken when beq and AluIgual=1, or when bne and AluIgual=0.
REQ-036 A taken branch SHALL assert PCwrite with SelMuxPC=1 in the same cycle (Mealy on AluIgual) and go to FETCH; a not-taken branch SHALL go to BR_NT.
REQ-037 HALT SHALL be absorbing, with all enables 0, until reset.

Reset
REQ-038 Asserting rst=0 at any time, including mid-instruction or during a memory wait, SHALL immediately force state FETCH, clear the wait counter and zero all registered outputs.
REQ-039 On the first rising clk edge after rst returns to 1, the block SHALL be in FETCH with no PCwrite, RegWrite or memory write issued.

Structure
REQ-040 The state enum, AluOperation codes, mux select codes and opcode constants SHALL live in a shared package riscv_ctrl_pkg.
REQ-041 The wait counter SHALL be a sub-module mem_wait_counter (load, count down, done flag); everything else stays in a single FSM.

Verification
REQ-042 MEM_WAIT=2, IR=0x002081B3 (add x3,x1,x2) -> 6 cycles; RegWrite and PCwrite in cycle 6; AluOperation=001 in R_EXEC.
REQ-043 IR=0x0000B183 (ld x3,0(x1)) -> 9 cycles; loadRegMemData in cycle 8; RegWrite with SelMuxMem=1 in cycle 9.
REQ-044 IR=0x00000063 (beq x0,x0,0) with AluIgual=1 -> PCwrite with SelMuxPC=1 in cycle 5; with AluIgual=0 -> BR_NT in cycle 6.
REQ-045 IR=0x00100073 (ebreak) -> HALT, which holds all enables 0 for 20 cycles.
REQ-046 rst=0 asserted in LD_WAIT -> State=FETCH within the same cycle; no RegWrite follows.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM: states, ALU ops,
// datapath mux selects and the opcode/funct constants the decoder dispatches on.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        FETCH_WAIT = 4'd1,
        DECODE     = 4'd2,
        R_EXEC     = 4'd3,
        I_EXEC     = 4'd4,
        ALU_WB     = 4'd5,
        ADDR       = 4'd6,
        LD_MEM     = 4'd7,
        LD_WAIT    = 4'd8,
        LD_WB      = 4'd9,
        SD_MEM     = 4'd10,
        BRANCH     = 4'd11,
        BR_NT      = 4'd12,
        LUI_WB     = 4'd13,
        HALT       = 4'd14
    } ctrlStateT;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [2:0] MUXA_PC   = 3'd0;
    localparam logic [2:0] MUXA_REGA = 3'd1;

    localparam logic [2:0] MUXB_REGB  = 3'd0;
    localparam logic [2:0] MUXB_FOUR  = 3'd1;
    localparam logic [2:0] MUXB_SIGN  = 3'd2;
    localparam logic [2:0] MUXB_SHIFT = 3'd3;

    localparam logic [2:0] MUXMEM_ALUOUT  = 3'd0;
    localparam logic [2:0] MUXMEM_MEMDATA = 3'd1;
    localparam logic [2:0] MUXMEM_IMM     = 3'd2;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_SD  = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that times memory-wait states: loaded on entry, counts to zero,
// and flags done while the count sits at zero.
module mem_wait_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             countEn,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (countEn && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/riscv_multicycle_control.sv
// Multicycle RISC-V control unit: one FSM sequencing fetch, decode, execute,
// memory and write-back, with memory waits timed by mem_wait_counter.
//
// state      | meaning
// FETCH      | issue instruction read, arm wait counter
// FETCH_WAIT | wait MEM_WAIT cycles, load IR on the last one
// DECODE     | load A/B, precompute branch target into AluOut, dispatch
// R_EXEC     | reg-reg ALU op into AluOut
// I_EXEC     | reg-imm add into AluOut
// ALU_WB     | write AluOut back, PC+4
// ADDR       | effective address into AluOut
// LD_MEM     | issue data read, arm wait counter
// LD_WAIT    | wait MEM_WAIT cycles, load MemData on the last one
// LD_WB      | write MemData back, PC+4
// SD_MEM     | data write, PC+4
// BRANCH     | compare; taken loads PC from AluOut here
// BR_NT      | not taken, PC+4
// LUI_WB     | write U-immediate back, PC+4
// HALT       | unsupported instruction, stuck until reset
module riscv_multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i31_0,
    input  logic        AluIgual,
    output logic        PCwrite,
    output logic        LoadIR,
    output logic        RegWrite,
    output logic        loadRegA,
    output logic        loadRegB,
    output logic        loadRegAluOut,
    output logic        loadRegMemData,
    output logic        MemRead,
    output logic        MemData_Read,
    output logic [2:0]  SelMuxA,
    output logic [2:0]  SelMuxB,
    output logic [2:0]  SelMuxMem,
    output logic        SelMuxPC,
    output logic [2:0]  AluOperation,
    output logic [3:0]  State
);

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

    ctrlStateT   state, nextState;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        waitLoad, waitCount, waitDone;
    logic        pcPlusFour, branchTaken;
    logic        unusedIrBits;

    assign opcode       = i31_0[6:0];
    assign funct3       = i31_0[14:12];
    assign funct7       = i31_0[31:25];
    assign unusedIrBits = ^{i31_0[24:15], i31_0[11:7]};
    assign State        = state;

    assign branchTaken = ((funct3 == F3_BEQ) && AluIgual) ||
                         ((funct3 == F3_BNE) && !AluIgual);

    mem_wait_counter #(.WIDTH(3)) uWaitCounter (
        .clk       (clk),
        .rst       (rst),
        .load      (waitLoad),
        .loadValue (WAIT_INIT),
        .countEn   (waitCount),
        .done      (waitDone)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= nextState;
    end

    always_comb begin
        nextState      = state;
        waitLoad       = 1'b0;
        waitCount      = 1'b0;
        pcPlusFour     = 1'b0;
        PCwrite        = 1'b0;
        LoadIR         = 1'b0;
        RegWrite       = 1'b0;
        loadRegA       = 1'b0;
        loadRegB       = 1'b0;
        loadRegAluOut  = 1'b0;
        loadRegMemData = 1'b0;
        MemRead        = 1'b0;
        MemData_Read   = 1'b0;
        SelMuxA        = MUXA_PC;
        SelMuxB        = MUXB_REGB;
        SelMuxMem      = MUXMEM_ALUOUT;
        SelMuxPC       = 1'b0;
        AluOperation   = ALU_PASS;

        case (state)
            FETCH: begin
                waitLoad  = 1'b1;
                nextState = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                waitCount = 1'b1;
                if (waitDone) begin
                    LoadIR    = 1'b1;
                    nextState = DECODE;
                end
            end
            DECODE: begin
                loadRegA      = 1'b1;
                loadRegB      = 1'b1;
                loadRegAluOut = 1'b1;
                SelMuxA       = MUXA_PC;
                SelMuxB       = MUXB_SHIFT;
                AluOperation  = ALU_ADD;
                case (opcode)
                    OP_RTYPE:  nextState = R_EXEC;
                    OP_ITYPE:  nextState = I_EXEC;
                    OP_LOAD:   nextState = (funct3 == F3_LD) ? ADDR : HALT;
                    OP_STORE:  nextState = (funct3 == F3_SD) ? ADDR : HALT;
                    OP_BRANCH: nextState = ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) ? BRANCH : HALT;
                    OP_LUI:    nextState = LUI_WB;
                    default:   nextState = HALT;
                endcase
            end
            R_EXEC: begin
                SelMuxA   = MUXA_REGA;
                SelMuxB   = MUXB_REGB;
                nextState = ALU_WB;
                if ((funct3 == F3_ADD) && (funct7 == F7_BASE)) begin
                    AluOperation  = ALU_ADD;
                    loadRegAluOut = 1'b1;
                end else if ((funct3 == F3_ADD) && (funct7 == F7_ALT)) begin
                    AluOperation  = ALU_SUB;
                    loadRegAluOut = 1'b1;
                end else if ((funct3 == F3_AND) && (funct7 == F7_BASE)) begin
                    AluOperation  = ALU_AND;
                    loadRegAluOut = 1'b1;
                end else begin
                    nextState = HALT;
                end
            end
            I_EXEC, ADDR: begin
                SelMuxA       = MUXA_REGA;
                SelMuxB       = MUXB_SIGN;
                AluOperation  = ALU_ADD;
                loadRegAluOut = 1'b1;
                if (state == I_EXEC)        nextState = ALU_WB;
                else if (opcode == OP_LOAD) nextState = LD_MEM;
                else                        nextState = SD_MEM;
            end
            LD_MEM: begin
                waitLoad  = 1'b1;
                nextState = LD_WAIT;
            end
            LD_WAIT: begin
                waitCount = 1'b1;
                if (waitDone) begin
                    loadRegMemData = 1'b1;
                    nextState      = LD_WB;
                end
            end
            ALU_WB: begin
                pcPlusFour = 1'b1;
                RegWrite   = 1'b1;
                SelMuxMem  = MUXMEM_ALUOUT;
            end
            LD_WB: begin
                pcPlusFour = 1'b1;
                RegWrite   = 1'b1;
                SelMuxMem  = MUXMEM_MEMDATA;
            end
            LUI_WB: begin
                pcPlusFour = 1'b1;
                RegWrite   = 1'b1;
                SelMuxMem  = MUXMEM_IMM;
            end
            SD_MEM: begin
                pcPlusFour   = 1'b1;
                MemData_Read = 1'b1;
            end
            BR_NT: pcPlusFour = 1'b1;
            BRANCH: begin
                SelMuxA      = MUXA_REGA;
                SelMuxB      = MUXB_REGB;
                AluOperation = ALU_SUB;
                if (branchTaken) begin
                    PCwrite   = 1'b1;
                    SelMuxPC  = 1'b1;
                    nextState = FETCH;
                end else begin
                    nextState = BR_NT;
                end
            end
            HALT:    nextState = HALT;
            default: nextState = FETCH;
        endcase

        // Shared tail of every instruction: PC <= PC + 4, then refetch.
        if (pcPlusFour) begin
            PCwrite      = 1'b1;
            SelMuxA      = MUXA_PC;
            SelMuxB      = MUXB_FOUR;
            AluOperation = ALU_ADD;
            SelMuxPC     = 1'b0;
            nextState    = FETCH;
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Scoreboard bench: per-cycle expected state/control words are queued for each
// instruction and popped against the DUT one cycle at a time.
module tb_riscv_multicycle_control;
    import riscv_ctrl_pkg::*;

    localparam int MW = 2;

    typedef struct packed {
        logic       pcW, irL, regW, la, lb, lAlu, lMd, memRd, mdWr;
        logic [2:0] selA, selB, selMem;
        logic       selPc;
        logic [2:0] aluOp;
    } ctlT;

    typedef struct packed {
        logic [3:0] st;
        ctlT        ctl;
    } expT;

    logic        clk, rst, AluIgual;
    logic [31:0] i31_0;
    logic        PCwrite, LoadIR, RegWrite, loadRegA, loadRegB, loadRegAluOut;
    logic        loadRegMemData, MemRead, MemData_Read, SelMuxPC;
    logic [2:0]  SelMuxA, SelMuxB, SelMuxMem, AluOperation;
    logic [3:0]  State;
    ctlT         dutCtl;

    expT sb[$];
    int  nCompared = 0;
    int  nMismatch = 0;
    int  cyc = 0;
    string testName = "";

    riscv_multicycle_control #(.MEM_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .i31_0(i31_0), .AluIgual(AluIgual),
        .PCwrite(PCwrite), .LoadIR(LoadIR), .RegWrite(RegWrite),
        .loadRegA(loadRegA), .loadRegB(loadRegB), .loadRegAluOut(loadRegAluOut),
        .loadRegMemData(loadRegMemData), .MemRead(MemRead), .MemData_Read(MemData_Read),
        .SelMuxA(SelMuxA), .SelMuxB(SelMuxB), .SelMuxMem(SelMuxMem),
        .SelMuxPC(SelMuxPC), .AluOperation(AluOperation), .State(State)
    );

    assign dutCtl = {PCwrite, LoadIR, RegWrite, loadRegA, loadRegB, loadRegAluOut,
                     loadRegMemData, MemRead, MemData_Read, SelMuxA, SelMuxB,
                     SelMuxMem, SelMuxPC, AluOperation};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctlT cZero();
        ctlT c = '0;
        return c;
    endfunction

    function automatic ctlT cDecode();
        ctlT c = '0;
        c.la = 1'b1; c.lb = 1'b1; c.lAlu = 1'b1;
        c.selA = 3'd0; c.selB = 3'd3; c.aluOp = 3'b001;
        return c;
    endfunction

    function automatic ctlT cReg(input logic [2:0] op, input logic ld);
        ctlT c = '0;
        c.selA = 3'd1; c.selB = 3'd0; c.aluOp = op; c.lAlu = ld;
        return c;
    endfunction

    function automatic ctlT cImm();
        ctlT c = '0;
        c.selA = 3'd1; c.selB = 3'd2; c.aluOp = 3'b001; c.lAlu = 1'b1;
        return c;
    endfunction

    function automatic ctlT cFinal(input logic regW, input logic [2:0] selMem, input logic mdWr);
        ctlT c = '0;
        c.pcW = 1'b1; c.selA = 3'd0; c.selB = 3'd1; c.aluOp = 3'b001; c.selPc = 1'b0;
        c.regW = regW; c.selMem = selMem; c.mdWr = mdWr;
        return c;
    endfunction

    function automatic ctlT cBranch(input logic taken);
        ctlT c = '0;
        c.selA = 3'd1; c.selB = 3'd0; c.aluOp = 3'b010;
        c.pcW = taken; c.selPc = taken;
        return c;
    endfunction

    task automatic pushE(input ctrlStateT st, input ctlT c);
        expT e;
        e.st  = st;
        e.ctl = c;
        sb.push_back(e);
    endtask

    task automatic pushFront();
        ctlT c;
        pushE(FETCH, cZero());
        for (int i = 0; i < MW; i++) begin
            c = cZero();
            c.irL = (i == MW - 1);
            pushE(FETCH_WAIT, c);
        end
        pushE(DECODE, cDecode());
    endtask

    task automatic pushLoadWait();
        ctlT c;
        pushE(LD_MEM, cZero());
        for (int i = 0; i < MW; i++) begin
            c = cZero();
            c.lMd = (i == MW - 1);
            pushE(LD_WAIT, c);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the last entry.
    task automatic drain();
        expT e;
        while (sb.size() > 0) begin
            #1;
            cyc++;
            e = sb.pop_front();
            checkVal($sformatf("%s c%0d state", testName, cyc), 32'(State), 32'(e.st));
            checkVal($sformatf("%s c%0d ctl", testName, cyc), 32'(dutCtl), 32'(e.ctl));
            @(negedge clk);
        end
    endtask

    task automatic runInstr(input string name, input logic [31:0] ir, input logic eq);
        testName = name;
        cyc = 0;
        rst = 1'b0;
        i31_0 = ir;
        AluIgual = eq;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drain();
    endtask

    initial begin
        rst = 1'b0;
        i31_0 = 32'h0;
        AluIgual = 1'b0;
        @(negedge clk);

        pushFront(); pushE(R_EXEC, cReg(3'b001, 1'b1)); pushE(ALU_WB, cFinal(1'b1, 3'd0, 1'b0)); pushE(FETCH, cZero());
        runInstr("add", 32'h002081B3, 1'b0);

        pushFront(); pushE(R_EXEC, cReg(3'b010, 1'b1)); pushE(ALU_WB, cFinal(1'b1, 3'd0, 1'b0)); pushE(FETCH, cZero());
        runInstr("sub", 32'h402081B3, 1'b0);

        pushFront(); pushE(R_EXEC, cReg(3'b011, 1'b1)); pushE(ALU_WB, cFinal(1'b1, 3'd0, 1'b0)); pushE(FETCH, cZero());
        runInstr("and", 32'h0020F1B3, 1'b0);

        pushFront(); pushE(R_EXEC, cReg(3'b000, 1'b0));
        for (int i = 0; i < 3; i++) pushE(HALT, cZero());
        runInstr("rbad", 32'h4020F1B3, 1'b0);

        pushFront(); pushE(I_EXEC, cImm()); pushE(ALU_WB, cFinal(1'b1, 3'd0, 1'b0)); pushE(FETCH, cZero());
        runInstr("addi", 32'h00108193, 1'b0);

        pushFront(); pushE(ADDR, cImm()); pushLoadWait(); pushE(LD_WB, cFinal(1'b1, 3'd1, 1'b0)); pushE(FETCH, cZero());
        runInstr("ld", 32'h0000B183, 1'b0);

        pushFront(); pushE(ADDR, cImm()); pushE(SD_MEM, cFinal(1'b0, 3'd0, 1'b1)); pushE(FETCH, cZero());
        runInstr("store", 32'h0020F023, 1'b0);

        pushFront(); pushE(HALT, cZero()); pushE(HALT, cZero());
        runInstr("ldbad", 32'h0000A183, 1'b0);

        pushFront(); pushE(LUI_WB, cFinal(1'b1, 3'd2, 1'b0)); pushE(FETCH, cZero());
        runInstr("lui", 32'h000001B7, 1'b0);

        pushFront(); pushE(BRANCH, cBranch(1'b1)); pushE(FETCH, cZero());
        runInstr("beq_t", 32'h00000063, 1'b1);

        pushFront(); pushE(BRANCH, cBranch(1'b0)); pushE(BR_NT, cFinal(1'b0, 3'd0, 1'b0)); pushE(FETCH, cZero());
        runInstr("beq_nt", 32'h00000063, 1'b0);

        pushFront(); pushE(BRANCH, cBranch(1'b1)); pushE(FETCH, cZero());
        runInstr("bne_t", 32'h00001063, 1'b0);

        pushFront(); pushE(BRANCH, cBranch(1'b0)); pushE(BR_NT, cFinal(1'b0, 3'd0, 1'b0)); pushE(FETCH, cZero());
        runInstr("bne_nt", 32'h00001063, 1'b1);

        pushFront(); pushE(HALT, cZero()); pushE(HALT, cZero());
        runInstr("blt", 32'h00004063, 1'b1);

        pushFront();
        for (int i = 0; i < 20; i++) pushE(HALT, cZero());
        runInstr("ebreak", 32'h00100073, 1'b0);

        // Reset dropped in the last LD_WAIT cycle must act without a clock edge.
        pushFront(); pushE(ADDR, cImm()); pushE(LD_MEM, cZero()); pushE(LD_WAIT, cZero());
        runInstr("ldrst", 32'h0000B183, 1'b0);
        rst = 1'b0;
        #1;
        checkVal("ldrst async state", 32'(State), 32'(FETCH));
        checkVal("ldrst async ctl", 32'(dutCtl), 32'(cZero()));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checkVal($sformatf("ldrst held%0d state", i), 32'(State), 32'(FETCH));
            checkVal($sformatf("ldrst held%0d regwrite", i), 32'(RegWrite), 32'(1'b0));
        end
        @(negedge clk);
        pushFront(); pushE(ADDR, cImm()); pushLoadWait(); pushE(LD_WB, cFinal(1'b1, 3'd1, 1'b0)); pushE(FETCH, cZero());
        runInstr("ldrecover", 32'h0000B183, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
